// File: rtl/store_buffer_if.sv
// rtl/store_buffer_if.sv - store-in, memory-write and load-probe signals of the store buffer
interface store_buffer_if;
    logic        st_valid;
    logic [63:0] st_addr;
    logic [63:0] st_data;
    logic [3:0]  st_size;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wstrb;
    logic        mem_ack;
    logic [63:0] ld_addr;
    logic        ld_conflict;

    modport master (
        output st_valid, st_addr, st_data, st_size, mem_ack, ld_addr,
        input  mem_req, mem_addr, mem_wdata, mem_wstrb, ld_conflict
    );

    modport slave (
        input  st_valid, st_addr, st_data, st_size, mem_ack, ld_addr,
        output mem_req, mem_addr, mem_wdata, mem_wstrb, ld_conflict
    );
endinterface

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - post-commit store queue draining to data memory over req/ack
// Also flags loads that hit the same 8-byte word as any pending store.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    store_buffer_if.slave bus,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output logic          overflow
);
    localparam int PW = $clog2(DEPTH);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_REQ  = 1'b1;

    logic [63:0] addr_q [DEPTH];
    logic [63:0] data_q [DEPTH];
    logic [3:0]  size_q [DEPTH];

    logic [0:0]    state, state_d;
    logic [PW-1:0] head, tail, head_nxt;
    logic          push, pop, load;
    logic [63:0]   nh_addr, nh_data;
    logic [3:0]    nh_size;
    logic [63:0]   mem_addr_q, mem_wdata_q;
    logic [7:0]    mem_wstrb_q;
    logic          conflict;
    logic [PW-1:0] off;

    function automatic logic [7:0] strobe_of(input logic [2:0] lo, input logic [3:0] size);
        logic [15:0] m;
        m = (16'd1 << size) - 16'd1;
        m = m << lo;
        return m[7:0];
    endfunction

    assign pop      = (state == S_REQ) && bus.mem_ack;
    assign push     = bus.st_valid && ((count != CW'(DEPTH)) || pop);
    assign head_nxt = head + PW'(1);

    // The memory-side registers are loaded with whichever store will be the
    // head next cycle; the incoming store is bypassed when the queue runs dry.
    always_comb begin
        state_d = state;
        load    = 1'b0;
        nh_addr = bus.st_addr;
        nh_data = bus.st_data;
        nh_size = bus.st_size;
        case (state)
            S_IDLE: begin
                if (push) begin
                    state_d = S_REQ;
                    load    = 1'b1;
                end
            end
            default: begin
                if (pop) begin
                    if (count > CW'(1)) begin
                        load    = 1'b1;
                        nh_addr = addr_q[head_nxt];
                        nh_data = data_q[head_nxt];
                        nh_size = size_q[head_nxt];
                    end else if (push) begin
                        load = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail] <= bus.st_addr;
            data_q[tail] <= bus.st_data;
            size_q[tail] <= bus.st_size;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            overflow    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
        end else begin
            state <= state_d;
            if (push) tail <= tail + PW'(1);
            if (pop)  head <= head_nxt;
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
            if (bus.st_valid && !push) overflow <= 1'b1;
            if (load) begin
                mem_addr_q  <= nh_addr & ~64'h7;
                mem_wdata_q <= nh_data << {nh_addr[2:0], 3'b000};
                mem_wstrb_q <= strobe_of(nh_addr[2:0], nh_size);
            end
        end
    end

    // An entry is live when its distance from head is below count.
    always_comb begin
        conflict = 1'b0;
        off      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PW'(i) - head;
            if ((CW'(off) < count) &&
                ((addr_q[i] & ~64'h7) == (bus.ld_addr & ~64'h7)))
                conflict = 1'b1;
        end
    end

    assign bus.mem_req     = (state == S_REQ);
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.mem_wstrb   = mem_wstrb_q;
    assign bus.ld_conflict = conflict;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
endmodule

// File: doc/store_buffer.md
# store_buffer

Post-commit store buffer sitting directly downstream of the retire stage. It accepts each store retired from the LSQ head, which arrives as an address, data and byte size, and queues it in program order. It drains stores one at a time to data memory over a req/ack handshake, generating byte-lane strobes and aligned write data. It also flags younger loads that overlap a pending store, and raises `full` so the top level can assert `retire_stall`.

## Interface
Parameters:
- `DEPTH`, 4: number of buffered stores; power of two, ≥2.
- `CW`, $clog2(DEPTH+1): width of `count`.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `st_valid`  in  1  retired store this cycle; driven by retire `lsq_decrement` qualified by a nonzero `le_size`.
- `st_addr`  in  64  byte address of the store (from `le`).
- `st_data`  in  64  store value, right-justified (from `le`).
- `st_size`  in  4  bytes written; legal values 1, 2, 4, 8 (retire `le_size`).
- `mem_req`  out  1  head store presented to memory.
- `mem_addr`  out  64  `{head.addr[63:3], 3'b000}`.
- `mem_wdata`  out  64  head data shifted left by `head.addr[2:0]*8`.
- `mem_wstrb`  out  8  `((1<<size)-1) << addr[2:0]`, truncated to 8 bits.
- `mem_ack`  in  1  memory accepted the presented write.
- `ld_addr`  in  64  address of the load being issued.
- `ld_conflict`  out  1  some valid entry has `addr[63:3] == ld_addr[63:3]`.
- `full`  out  1  `count == DEPTH`.
- `empty`  out  1  `count == 0`.
- `count`  out  CW  number of valid entries.
- `overflow`  out  1  sticky; a store was dropped.

## Operation
- Storage: circular array of DEPTH entries {addr, data, size}. `head` and `tail` pointers are log2(DEPTH) bits wide and wrap modulo DEPTH. `count` is tracked separately.
- Drain FSM, two states:
  - IDLE: `mem_req`=0. Moves to REQ on the cycle after `count` becomes nonzero.
  - REQ: `mem_req`=1, with `mem_addr`/`mem_wdata`/`mem_wstrb` driven from the head entry. These are registered and held stable until ack.
  - On `mem_ack` in REQ: pop the head (head+1, count−1). Stay in REQ if entries remain after the pop, else go to IDLE.
- `mem_ack` is ignored in IDLE.
- Enqueue is accepted when `st_valid` and (`count < DEPTH` or a pop occurs this cycle). The entry is written at `tail` and tail+1.
- Simultaneous push and pop leaves `count` unchanged.
- `st_valid` with the buffer full and no pop: the store is dropped and `overflow` is set. Only `reset` clears `overflow`.
- Strobe and data: byte lanes outside the 8-byte word are discarded. Alignment is guaranteed upstream, so this is not an error.
- `ld_conflict` is purely combinational over all valid entries, including the head currently in REQ. It is 0 when empty.
- Pipeline `flush` from retire has no effect: buffered stores are already committed.

## Timing
- Reset values: `mem_req`=0, `mem_addr`=0, `mem_wdata`=0, `mem_wstrb`=0, `full`=0, `empty`=1, `count`=0, `overflow`=0, `ld_conflict`=0. FSM resets to IDLE and pointers to 0.
- Reset asserted mid-handshake drops `mem_req` asynchronously; all pending stores are lost.
- Latency into an empty buffer:
  - Store presented at cycle N → `mem_req`=1 in cycle N+1.
  - Ack in cycle N+1 → `empty`=1 in N+2.
- Back-to-back throughput: one store per cycle while `mem_ack` is held high. The next head appears in the cycle after each ack.
- `full`, `empty` and `count` reflect registered state and update on the clock edge after a push or pop.
- `ld_conflict` sees an entry from the cycle after it is enqueued; the same-cycle retiring store is not checked.

## Test plan
- Single SW: addr 0x1004, data 0xDEADBEEF, size 4 → next cycle `mem_req`=1, `mem_addr`=0x1000, `mem_wdata`=0xDEADBEEF_00000000, `mem_wstrb`=0xF0. Ack → `empty`=1.
- Fill: push 4 stores with `mem_ack`=0 → `full`=1, `count`=4. A 5th push sets `overflow`=1 and `count` stays 4. Drain with acks returns the first 4 stores in order.
- Full with simultaneous push and ack: 5th store is accepted, `count` stays 4, `overflow` stays 0. Wrap-around order is preserved over 10 stores.
- Sizes: SB at 0x7 → strobe 0x80, data << 56. SH at 0x2 → strobe 0x0C. SD at 0x8 → strobe 0xFF, `mem_addr`=0x8.
- Conflict: store at 0x2000 pending, `ld_addr`=0x2006 → `ld_conflict`=1. `ld_addr`=0x2008 → 0. After ack drains it → 0.
- Reset mid-REQ with 3 entries → `mem_req` drops immediately, `count`=0, `empty`=1, `overflow`=0.
